// File: rtl/apb_req_mst.sv
`default_nettype none
// ============================================================================
// apb_req_mst : valid/ready command channel -> single outstanding APB4 transfer
// Optional ACCESS-stall abort: define APB_MST_TIMEOUT_EN.   Revision: 1.0
// ============================================================================
module apb_req_mst #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH/8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_WIDTH-1:0] PSTRB,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR,
  output logic                  timeout_flag
);

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32) ||
      STRB_WIDTH != DATA_WIDTH/8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_req_mst: DATA_WIDTH must be 8/16/32, STRB_WIDTH = DATA_WIDTH/8, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                r_state,     w_state_nxt;
  logic                  r_req_ready, w_req_ready_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err,   w_rsp_err_nxt;
  logic                  r_psel,      w_psel_nxt;
  logic                  r_penable,   w_penable_nxt;
  logic [ADDR_WIDTH-1:0] r_paddr,     w_paddr_nxt;
  logic                  r_pwrite,    w_pwrite_nxt;
  logic [DATA_WIDTH-1:0] r_pwdata,    w_pwdata_nxt;
  logic [STRB_WIDTH-1:0] r_pstrb,     w_pstrb_nxt;

`ifdef APB_MST_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  // Abort fires on the stalled cycle that would bring the count to the limit.
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_tmo_cnt,  w_tmo_cnt_nxt;
  logic               r_tmo_flag, w_tmo_flag_nxt;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_pstrb     <= w_pstrb_nxt;
    end
  end

`ifdef APB_MST_TIMEOUT_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tmo_cnt  <= '0;
      r_tmo_flag <= 1'b0;
    end else begin
      r_tmo_cnt  <= w_tmo_cnt_nxt;
      r_tmo_flag <= w_tmo_flag_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_req_ready_nxt = r_req_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_paddr_nxt     = r_paddr;
    w_pwrite_nxt    = r_pwrite;
    w_pwdata_nxt    = r_pwdata;
    w_pstrb_nxt     = r_pstrb;
`ifdef APB_MST_TIMEOUT_EN
    w_tmo_cnt_nxt   = r_tmo_cnt;
    w_tmo_flag_nxt  = r_tmo_flag;
`endif

    case (r_state)
      ST_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_state_nxt     = ST_SETUP;
          w_req_ready_nxt = 1'b0;
          w_psel_nxt      = 1'b1;
          w_paddr_nxt     = req_addr;
          w_pwrite_nxt    = req_write;
          // APB4 reads carry no write data and no strobes.
          w_pwdata_nxt    = req_write ? req_wdata : '0;
          w_pstrb_nxt     = req_write ? req_strb  : '0;
`ifdef APB_MST_TIMEOUT_EN
          w_tmo_cnt_nxt   = '0;
`endif
        end else begin
          w_req_ready_nxt = 1'b1;
        end
      end

      ST_SETUP: begin
        w_state_nxt   = ST_ACCESS;
        w_penable_nxt = 1'b1;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          w_state_nxt     = ST_RESP;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_pwrite ? '0 : PRDATA;
          w_rsp_err_nxt   = PSLVERR;
        end
`ifdef APB_MST_TIMEOUT_EN
        else if (r_tmo_cnt == c_cnt_last) begin
          w_state_nxt     = ST_RESP;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = '0;
          w_rsp_err_nxt   = 1'b1;
          w_tmo_flag_nxt  = 1'b1;
        end else begin
          w_tmo_cnt_nxt   = r_tmo_cnt + 1'b1;
        end
`endif
      end

      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PADDR     = r_paddr;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;

`ifdef APB_MST_TIMEOUT_EN
  assign timeout_flag = r_tmo_flag;
`else
  assign timeout_flag = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/apb_req_mst.md
Name: apb_req_mst

Overview:
- Upstream APB requester for the dual-port memory slave.
- Accepts single read/write commands on a valid/ready request channel and converts each into an APB4 SETUP/ACCESS transfer.
- Waits for PREADY, then returns PRDATA/PSLVERR on a valid/ready response channel.
- One outstanding transfer at a time; the block plays the AHB2APB-bridge role in the memory test system.

Parameters:
- ADDR_WIDTH, 32, width of req_addr/PADDR
- DATA_WIDTH, 32, width of data buses; must be 8, 16 or 32
- STRB_WIDTH, DATA_WIDTH/8, byte-lane strobe width
- TIMEOUT_CYCLES, 16, ACCESS cycles with PREADY low before abort (used only with APB_MST_TIMEOUT_EN)

Ports:
- PCLK  in  1  system clock; all logic on posedge
- PRESETn  in  1  asynchronous active-low reset
- req_valid  in  1  command present
- req_ready  out  1  command accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  transfer address
- req_wdata  in  DATA_WIDTH  write data
- req_strb  in  STRB_WIDTH  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_err  out  1  PSLVERR captured, or timeout
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  ADDR_WIDTH  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PSTRB  out  STRB_WIDTH  APB strobes
- PREADY  in  1  slave ready
- PRDATA  in  DATA_WIDTH  slave read data
- PSLVERR  in  1  slave error
- timeout_flag  out  1  sticky timeout indicator

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 (req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, timeout_flag); timeout counter 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready = 1 (registered; it drops in the cycle after acceptance). On handshake at edge N, register the command into the APB outputs and go to SETUP.
- SETUP (cycle N+1): PSEL=1, PENABLE=0. Unconditionally go to ACCESS.
- ACCESS (from N+2): PSEL=1, PENABLE=1. PADDR, PWRITE, PWDATA and PSTRB hold stable until the transfer completes.
  - PREADY=0: stay in ACCESS (wait states unbounded unless timeout enabled).
  - PREADY=1 at edge M: capture PRDATA (reads) or 0 (writes) into rsp_rdata, and PSLVERR into rsp_err. Set rsp_valid=1 and PSEL=PENABLE=0 from M+1; go to RESP.
- Zero-wait transfer: request accepted at N, rsp_valid at N+3.
- RESP: rsp_valid, rsp_rdata and rsp_err hold until rsp_ready.
  - On handshake: rsp_valid=0, go to IDLE, req_ready=1 next cycle.
  - rsp_ready held high continuously: back-to-back throughput of one transfer per 4 cycles.
- Reads: PWDATA=0 and PSTRB=0 (APB4). Writes: PWDATA=req_wdata, PSTRB=req_strb. A write with req_strb=0 is still issued.
- After completion, PADDR/PWRITE/PWDATA/PSTRB keep their last values; only PSEL/PENABLE return to 0.
- Request inputs are ignored outside IDLE.
- Reset asserted mid-transfer: immediate return to reset values; the in-flight command and any pending response are discarded, with no response issued.

Optional Feature:
- Macro: APB_MST_TIMEOUT_EN.
- Enabled:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) increments each ACCESS cycle with PREADY=0 and clears on entering SETUP.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0: drop PSEL/PENABLE, rsp_rdata=0, rsp_err=1, go to RESP.
  - timeout_flag sets and stays 1 until reset.
  - PREADY=1 in the same cycle the limit is reached counts as normal completion.
- Disabled: no counter; timeout_flag tied 0; ACCESS waits indefinitely.

Test Plan:
- Write req addr=0x10, wdata=0xDEADBEEF, strb=0xF; PREADY=1 immediately -> PSEL at N+1, PENABLE at N+2, PWDATA=0xDEADBEEF, PSTRB=0xF; rsp_valid at N+3, rsp_rdata=0, rsp_err=0.
- Read addr=0x10; slave inserts 3 wait states, then PRDATA=0xDEADBEEF -> PADDR and PSEL/PENABLE stable through waits; PSTRB=0, PWDATA=0; rsp_rdata=0xDEADBEEF at N+6.
- Read with PSLVERR=1 at completion -> rsp_err=1; next request accepted only after the rsp handshake.
- Hold rsp_ready=0 for 5 cycles, req_valid=1 throughout -> req_ready stays 0, rsp fields stable, no APB activity; 2nd transfer SETUP starts 2 cycles after rsp_ready rises.
- Deassert PRESETn during ACCESS -> all outputs 0 immediately; after release, req_ready=1 on the first clock and no stale response appears.
- APB_MST_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4 waiting ACCESS cycles; rsp_err=1, rsp_rdata=0, timeout_flag=1 until reset.
